// File: rtl/uart_frame_writer_if.sv
// uart_frame_writer_if
//   Bundles the frame request, payload stream and TX FIFO write port of the
//   UART frame writer.
//   Signals:
//     start, len              frame request and payload length
//     pl_data, pl_valid,      payload byte stream (valid/ready)
//     pl_ready
//     fifo_full, fifo_wr,     TX FIFO write port
//     fifo_wr_data
//     busy, done_tick,        status
//     err_tick
//   Modports: slave = the frame writer, master = the side that drives it.
interface uart_frame_writer_if #(
  parameter int DBITS    = 8,
  parameter int LEN_BITS = 5
);
  logic                start;
  logic [LEN_BITS-1:0] len;
  logic [DBITS-1:0]    pl_data;
  logic                pl_valid;
  logic                pl_ready;
  logic                fifo_full;
  logic                fifo_wr;
  logic [DBITS-1:0]    fifo_wr_data;
  logic                busy;
  logic                done_tick;
  logic                err_tick;

  modport slave (
    input  start, len, pl_data, pl_valid, fifo_full,
    output pl_ready, fifo_wr, fifo_wr_data, busy, done_tick, err_tick
  );

  modport master (
    output start, len, pl_data, pl_valid, fifo_full,
    input  pl_ready, fifo_wr, fifo_wr_data, busy, done_tick, err_tick
  );
endinterface

// File: rtl/uart_frame_writer.sv
// uart_frame_writer
//   Wraps a payload byte stream into a UART frame
//     SOF, LEN, payload[0..LEN-1], XOR checksum
//   and writes it into the TX FIFO one byte per cycle, stalling on fifo_full.
//   Optional feature macro: UART_FRAME_CSUM_EN. When it is undefined the
//   checksum byte and the checksum register are left out and the frame ends
//   after the last payload byte.
//   Ports:
//     ckht  system clock (rising edge)
//     rst   asynchronous active-high reset
//     bus   uart_frame_writer_if.slave: request, payload stream, FIFO port,
//           busy/done_tick/err_tick status
module uart_frame_writer #(
  parameter int               DBITS    = 8,
  parameter int               MAX_LEN  = 16,
  parameter int               LEN_BITS = 5,
  parameter logic [DBITS-1:0] SOF      = 8'hA5
) (
  input  logic              ckht,
  input  logic              rst,
  uart_frame_writer_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SOF_S  = 3'd1;
  localparam logic [2:0] LEN_S  = 3'd2;
  localparam logic [2:0] PAY_S  = 3'd3;
`ifdef UART_FRAME_CSUM_EN
  localparam logic [2:0] CSUM_S = 3'd4;
`endif

  localparam logic [LEN_BITS-1:0] MAX_LEN_V = LEN_BITS'(MAX_LEN);
  localparam logic [LEN_BITS-1:0] ONE_V     = LEN_BITS'(1);

  logic [2:0]          state_q, state_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef UART_FRAME_CSUM_EN
  logic [DBITS-1:0]    csum_q, csum_d;
`endif

  logic                wr;
  logic [DBITS-1:0]    wr_data;
  logic                rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef UART_FRAME_CSUM_EN
    csum_d  = csum_q;
`endif
    wr      = 1'b0;
    wr_data = '0;
    rdy     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0 && bus.len <= MAX_LEN_V) begin
            len_d   = bus.len;
            cnt_d   = bus.len;
`ifdef UART_FRAME_CSUM_EN
            csum_d  = '0;
`endif
            state_d = SOF_S;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SOF_S: begin
        wr_data = SOF;
        if (!bus.fifo_full) begin
          wr      = 1'b1;
          state_d = LEN_S;
        end
      end

      LEN_S: begin
        wr_data = DBITS'(len_q);
        if (!bus.fifo_full) begin
          wr      = 1'b1;
          state_d = PAY_S;
        end
      end

      PAY_S: begin
        rdy     = !bus.fifo_full;
        wr_data = bus.pl_data;
        if (bus.pl_valid && !bus.fifo_full) begin
          wr    = 1'b1;
          cnt_d = cnt_q - ONE_V;
`ifdef UART_FRAME_CSUM_EN
          csum_d = csum_q ^ bus.pl_data;
          if (cnt_q == ONE_V) state_d = CSUM_S;
`else
          if (cnt_q == ONE_V) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`endif
        end
      end

`ifdef UART_FRAME_CSUM_EN
      CSUM_S: begin
        wr_data = csum_q;
        if (!bus.fifo_full) begin
          wr      = 1'b1;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef UART_FRAME_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.fifo_wr      = wr;
  assign bus.fifo_wr_data = wr_data;
  assign bus.pl_ready     = rdy;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done_tick    = done_q;
  assign bus.err_tick     = err_q;

endmodule
